// File: rtl/pwm_mmio_bank.sv
// Memory-mapped multi-channel PWM bank: prescaled shared timebase, double-buffered period/duty,
// polarity control and a one-clock pulse at every period wrap.
module pwm_mmio_bank #(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 16,
  parameter int          PRESC_W   = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_F000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [31:0]       DataAdr,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              hit,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_irq
);

  logic               r_en;
  logic               r_inv;
  logic [CNT_W-1:0]   r_period;
  logic [PRESC_W-1:0] r_presc;
  logic [CNT_W-1:0]   r_duty     [NUM_CH];
  logic [CNT_W-1:0]   r_period_act;
  logic [CNT_W-1:0]   r_duty_act [NUM_CH];
  logic [PRESC_W-1:0] r_presc_cnt;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_CH-1:0]  r_pwm;
  logic               r_irq;

  logic [5:0]  w_word;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_period;
  logic        w_wr_presc;
  logic        w_en_next;
  logic        w_tick;
  logic        w_wrap;
  logic [15:0] w_cnt16;
  logic        w_unused;

  assign hit         = (DataAdr[31:8] == BASE_ADDR[31:8]);
  assign w_word      = DataAdr[7:2];
  assign w_wr        = MemWrite & hit;
  assign w_wr_ctrl   = w_wr && (w_word == 6'd0);
  assign w_wr_period = w_wr && (w_word == 6'd1);
  assign w_wr_presc  = w_wr && (w_word == 6'd2);
  // Outputs are gated by both the current and the incoming EN so that enabling
  // delays the first compare by one clock and disabling drops outputs immediately.
  assign w_en_next   = w_wr_ctrl ? WriteData[0] : r_en;
  assign w_tick      = r_en && (r_presc_cnt == r_presc);
  assign w_wrap      = w_tick && (r_cnt == r_period_act);
  assign w_cnt16     = 16'(r_cnt);
  assign w_unused    = ^{DataAdr[1:0], WriteData};

  assign pwm_out     = r_pwm;
  assign period_irq  = r_irq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en         <= 1'b0;
      r_inv        <= 1'b0;
      r_period     <= CNT_W'(255);
      r_presc      <= '0;
      r_period_act <= CNT_W'(255);
      r_presc_cnt  <= '0;
      r_cnt        <= '0;
      r_pwm        <= '0;
      r_irq        <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_duty[i]     <= '0;
        r_duty_act[i] <= '0;
      end
    end else begin
      if (w_wr_ctrl) begin
        r_en  <= WriteData[0];
        r_inv <= WriteData[1];
      end
      if (w_wr_period) r_period <= WriteData[CNT_W-1:0];
      if (w_wr_presc)  r_presc  <= WriteData[PRESC_W-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr && (w_word == 6'(4 + i))) r_duty[i] <= WriteData[CNT_W-1:0];
      end

      if (!w_en_next || w_wr_presc || w_tick) r_presc_cnt <= '0;
      else if (r_en)                          r_presc_cnt <= r_presc_cnt + PRESC_W'(1);

      if (!w_en_next || w_wrap) r_cnt <= '0;
      else if (w_tick)          r_cnt <= r_cnt + CNT_W'(1);

      // Active copies load the pre-edge shadows, so a same-edge write waits a period.
      if (!r_en || w_wrap) begin
        r_period_act <= r_period;
        r_duty_act   <= r_duty;
      end

      r_irq <= w_wrap & w_en_next;
      for (int i = 0; i < NUM_CH; i++) begin
        r_pwm[i] <= r_en & w_en_next & ((r_cnt < r_duty_act[i]) ^ r_inv);
      end
    end
  end

  always_comb begin
    ReadData = '0;
    if (hit) begin
      case (w_word)
        6'd0:    ReadData = {30'd0, r_inv, r_en};
        6'd1:    ReadData = 32'(r_period);
        6'd2:    ReadData = 32'(r_presc);
        6'd3:    ReadData = {w_cnt16, 15'd0, r_en};
        default: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (w_word == 6'(4 + i)) ReadData = 32'(r_duty[i]);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_mmio_bank.sv
// Self-checking bench for pwm_mmio_bank: a clocks-into-period reference model checked every cycle,
// plus directed scenarios with hand-computed waveform counts and register values.
module tb_pwm_mmio_bank;

  localparam int          NUM_CH = 4;
  localparam logic [31:0] BASE   = 32'hFFFF_F000;

  logic              clk = 1'b0;
  logic              reset;
  logic              MemWrite;
  logic [31:0]       DataAdr;
  logic [31:0]       WriteData;
  logic [31:0]       ReadData;
  logic              hit;
  logic [NUM_CH-1:0] pwm_out;
  logic              period_irq;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pwm_mmio_bank #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (16),
    .PRESC_W  (8),
    .BASE_ADDR(BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .hit       (hit),
    .pwm_out   (pwm_out),
    .period_irq(period_irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position inside the current period is a plain clock count m_k,
  // counter value = m_k / (PRESC+1), wrap happens on the last clock of
  // (period+1)*(PRESC+1).
  bit                m_valid = 1'b0;
  bit                m_en, m_inv;
  int                m_period, m_presc;
  int                m_duty [NUM_CH];
  int                m_pact;
  int                m_dact [NUM_CH];
  longint            m_k;
  logic [NUM_CH-1:0] m_pwm;
  bit                m_irq;
  bit                m_w, m_wrap, m_en_next;
  int                m_word, m_newp;
  longint            m_cnt_old;

  function automatic bit m_hit(input logic [31:0] a);
    return a[31:8] == BASE[31:8];
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int wd;
    wd = int'(a[7:2]);
    if (!m_hit(a)) return 32'd0;
    if (wd == 0) return {30'd0, m_inv, m_en};
    if (wd == 1) return 32'(m_period);
    if (wd == 2) return 32'(m_presc);
    if (wd == 3) return {16'(m_k / (m_presc + 1)), 15'd0, m_en};
    if (wd >= 4 && wd < 4 + NUM_CH) return 32'(m_duty[wd-4]);
    return 32'd0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_en = 0; m_inv = 0; m_period = 255; m_presc = 0; m_pact = 255;
      m_k = 0; m_pwm = '0; m_irq = 0;
      for (int i = 0; i < NUM_CH; i++) begin m_duty[i] = 0; m_dact[i] = 0; end
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_w       = MemWrite && m_hit(DataAdr);
      m_word    = int'(DataAdr[7:2]);
      m_cnt_old = m_k / (m_presc + 1);
      m_wrap    = m_en && (m_k == longint'(m_pact + 1) * (m_presc + 1) - 1);
      m_en_next = (m_w && m_word == 0) ? WriteData[0] : m_en;
      for (int i = 0; i < NUM_CH; i++)
        m_pwm[i] = m_en & m_en_next & ((m_cnt_old < m_dact[i]) ^ m_inv);
      m_irq = m_wrap & m_en_next;
      if (!m_en_next || !m_en || m_wrap) m_k = 0;
      else m_k = m_k + 1;
      if (!m_en || m_wrap) begin
        m_pact = m_period;
        m_dact = m_duty;
      end
      if (m_w) begin
        if (m_word == 0) begin m_en = WriteData[0]; m_inv = WriteData[1]; end
        else if (m_word == 1) m_period = int'(WriteData[15:0]);
        else if (m_word == 2) begin
          m_newp = int'(WriteData[7:0]);
          m_k = (m_k / (m_presc + 1)) * (m_newp + 1);
          m_presc = m_newp;
        end else if (m_word >= 4 && m_word < 4 + NUM_CH) m_duty[m_word-4] = int'(WriteData[15:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("pwm_out", 32'(pwm_out), 32'(m_pwm));
      check("period_irq", 32'(period_irq), 32'(m_irq));
      check("hit", 32'(hit), 32'(m_hit(DataAdr)));
      check("ReadData", ReadData, m_read(DataAdr));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    MemWrite = 1'b1; DataAdr = BASE + off; WriteData = d;
    @(posedge clk); #1;
    MemWrite = 1'b0; DataAdr = BASE + 32'h0C;
  endtask

  task automatic rd(input string name, input logic [31:0] off, input logic [31:0] exp);
    DataAdr = BASE + off;
    #1;
    check(name, ReadData, exp);
    @(posedge clk); #1;
  endtask

  task automatic count_win(input int n, input int ch, output int hi, output int irqs);
    hi = 0; irqs = 0;
    repeat (n) begin
      @(negedge clk);
      hi   += int'(pwm_out[ch]);
      irqs += int'(period_irq);
    end
  endtask

  task automatic wait_irq(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (period_irq !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (period_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: period_irq not seen within 40 clks", name);
    end
  endtask

  int h, q, h1, h2, h3, q1, q2, q3;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; MemWrite = 1'b0; DataAdr = BASE; WriteData = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // T1 reset values
    rd("t1_ctrl", 32'h00, 32'd0);
    rd("t1_period", 32'h04, 32'd255);
    rd("t1_presc", 32'h08, 32'd0);
    rd("t1_status", 32'h0C, 32'd0);
    for (int i = 0; i < NUM_CH; i++) rd("t1_duty", 32'h10 + 32'(4 * i), 32'd0);
    check("t1_pwm", 32'(pwm_out), 32'd0);
    check("t1_irq", 32'(period_irq), 32'd0);

    // T2 basic PWM, with upper-bit truncation of PERIOD
    wr(32'h04, 32'h0001_0003);
    rd("t2_period_trunc", 32'h04, 32'd3);
    wr(32'h08, 32'd0);
    wr(32'h10, 32'd2);
    wr(32'h00, 32'd1);
    step(2);
    count_win(12, 0, h, q);
    @(posedge clk); #1;
    check("t2_high_clks", 32'(h), 32'd6);
    check("t2_irqs", 32'(q), 32'd3);

    // T3 prescaler
    wr(32'h00, 32'd0);
    wr(32'h08, 32'd2);
    wr(32'h10, 32'd1);
    wr(32'h00, 32'd1);
    step(2);
    count_win(24, 0, h, q);
    @(posedge clk); #1;
    check("t3_high_clks", 32'(h), 32'd6);
    check("t3_irqs", 32'(q), 32'd2);

    // T4 double buffering: mid-period write, then write on the wrap edge
    wr(32'h00, 32'd0);
    wr(32'h08, 32'd0);
    wr(32'h10, 32'd2);
    wr(32'h00, 32'd1);
    step(1);
    wait_irq("t4_sync_a");
    fork
      begin count_win(4, 0, h1, q1); count_win(4, 0, h2, q2); end
      begin @(posedge clk); #1; wr(32'h10, 32'd3); end
    join
    check("t4_mid_cur", 32'(h1), 32'd2);
    check("t4_mid_next", 32'(h2), 32'd3);
    wait_irq("t4_sync_b");
    fork
      begin count_win(4, 0, h1, q1); count_win(4, 0, h2, q2); count_win(4, 0, h3, q3); end
      begin @(posedge clk); #1; step(2); wr(32'h10, 32'd1); end
    join
    @(posedge clk); #1;
    check("t4_wrap_cur", 32'(h1), 32'd3);
    check("t4_wrap_next", 32'(h2), 32'd3);
    check("t4_wrap_after", 32'(h3), 32'd1);

    // T5 duty edge cases with inversion, then disable
    wr(32'h00, 32'd0);
    wr(32'h14, 32'd0);
    wr(32'h18, 32'd4);
    wr(32'h00, 32'd3);
    step(6);
    repeat (4) begin
      @(negedge clk);
      check("t5_duty0_inv", 32'(pwm_out[1]), 32'd1);
      check("t5_dutybig_inv", 32'(pwm_out[2]), 32'd0);
    end
    @(posedge clk); #1;
    wr(32'h00, 32'd0);
    check("t5_disable_pwm", 32'(pwm_out), 32'd0);
    check("t5_disable_irq", 32'(period_irq), 32'd0);

    // T6 address decode and mid-period reset
    wr(32'h00, 32'd1);
    step(3);
    MemWrite = 1'b1; DataAdr = BASE + 32'h100; WriteData = 32'hFFFF;
    #1;
    check("t6_out_of_window_hit", 32'(hit), 32'd0);
    check("t6_out_of_window_rd", ReadData, 32'd0);
    @(posedge clk); #1;
    MemWrite = 1'b0;
    wr(32'h20, 32'h55);
    rd("t6_period", 32'h04, 32'd3);
    rd("t6_presc", 32'h08, 32'd0);
    rd("t6_duty0", 32'h10, 32'd1);
    rd("t6_unmapped", 32'h20, 32'd0);
    rd("t6_ctrl", 32'h00, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t6_reset_pwm", 32'(pwm_out), 32'd0);
    check("t6_reset_irq", 32'(period_irq), 32'd0);
    rd("t6_reset_ctrl", 32'h00, 32'd0);
    rd("t6_reset_period", 32'h04, 32'd255);
    rd("t6_reset_duty0", 32'h10, 32'd0);
    reset = 1'b0;
    step(3);
    check("t6_after_reset_pwm", 32'(pwm_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
